// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, addresses the combinational instruction ROM,
// and holds the fetched word in an IF/ID register behind a valid/ready handshake.
module ifetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [XLEN-1:0] imem_adr,
  input  logic [XLEN-1:0] imem_inst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_inst,
  output logic [XLEN-1:0] if_pc_plus4,
  output logic            misalign_err,
  output logic [XLEN-1:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t          state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic            valid_nxt;
  logic            err_nxt;
  logic            capture;
  logic            fire;
  logic            load_ok;
  logic            misaligned;

  assign imem_adr   = pc;
  assign fire       = if_valid & if_ready;
  assign load_ok    = !if_valid | if_ready;
  assign misaligned = redirect_pc[1:0] != 2'b00;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    valid_nxt = if_valid;
    err_nxt   = misalign_err;
    capture   = 1'b0;
    case (state)
      BOOT, RUN: begin
        if (redirect_valid && misaligned) begin
          state_nxt = HALT;
          err_nxt   = 1'b1;
          valid_nxt = 1'b0;
        end else if (redirect_valid) begin
          // Flush: the word currently on imem_inst belongs to the wrong path.
          state_nxt = RUN;
          pc_nxt    = redirect_pc;
          valid_nxt = 1'b0;
        end else if (state == BOOT) begin
          state_nxt = RUN;
        end else if (load_ok) begin
          capture   = 1'b1;
          valid_nxt = 1'b1;
          pc_nxt    = pc + XLEN'(4);
        end
      end
      HALT: begin
        valid_nxt = 1'b0;
      end
      default: begin
        state_nxt = HALT;
        valid_nxt = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      if_valid     <= 1'b0;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      if_valid     <= valid_nxt;
      misalign_err <= err_nxt;
      // A handshake in a flushing cycle still delivered its instruction.
      fetch_count  <= fetch_count + XLEN'(fire);
    end
  end

  // IF/ID payload only moves on a capture, which keeps it frozen during stalls and HALT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_pc       <= '0;
      if_inst     <= '0;
      if_pc_plus4 <= '0;
    end else if (capture) begin
      if_pc       <= pc;
      if_inst     <= imem_inst;
      if_pc_plus4 <= pc + XLEN'(4);
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Self-checking bench for ifetch_unit: a behavioural fetch model driven with
// directed and $urandom stimulus, compared every step against the DUT.
module tb_ifetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_adr, imem_inst;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_valid;
  logic        if_ready = 1'b0;
  logic [31:0] if_pc, if_inst, if_pc_plus4, fetch_count;
  logic        misalign_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [31:0] m_pc, m_ipc, m_inst, m_p4, m_count;
  logic        m_valid, m_err, m_boot, m_halt;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] adr);
    return 32'h1000_0000 + (adr >> 2);
  endfunction

  assign imem_inst = rom(imem_adr);

  ifetch_unit #(.XLEN(32), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .rst_n(rst_n), .imem_adr(imem_adr), .imem_inst(imem_inst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready), .if_pc(if_pc), .if_inst(if_inst),
    .if_pc_plus4(if_pc_plus4), .misalign_err(misalign_err), .fetch_count(fetch_count)
  );

  function automatic logic [161:0] dut_snap();
    return {if_valid, if_pc, if_inst, if_pc_plus4, misalign_err, fetch_count, imem_adr};
  endfunction

  function automatic logic [161:0] model_snap();
    return {m_valid, m_ipc, m_inst, m_p4, m_err, m_count, m_pc};
  endfunction

  task automatic model_reset();
    m_pc = RESET_PC; m_ipc = '0; m_inst = '0; m_p4 = '0; m_count = '0;
    m_valid = 1'b0; m_err = 1'b0; m_boot = 1'b1; m_halt = 1'b0;
  endtask

  // One clock: drive inputs away from the edge, advance the model at the edge,
  // return 1 time unit later so callers sample settled outputs.
  task automatic step(input logic rv, input logic [31:0] rpc, input logic rdy);
    redirect_valid = rv;
    redirect_pc    = rpc;
    if_ready       = rdy;
    @(posedge clk);
    if (m_valid && rdy) m_count = m_count + 1;
    if (!m_halt) begin
      if (rv && rpc[1:0] != 2'b00) begin
        m_halt = 1'b1; m_err = 1'b1; m_valid = 1'b0;
      end else if (rv) begin
        m_pc = rpc; m_valid = 1'b0; m_boot = 1'b0;
      end else if (m_boot) begin
        m_boot = 1'b0;
      end else if (!m_valid || rdy) begin
        m_ipc = m_pc; m_inst = rom(m_pc); m_p4 = m_pc + 4;
        m_valid = 1'b1; m_pc = m_pc + 4;
      end
    end else begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    redirect_valid = 1'b0;
    if_ready = 1'b0;
    model_reset();
    #3;
    n_checks++;
    if (dut_snap() !== model_snap()) begin
      n_fail++;
      $display("FAIL reset_state got=%h exp=%h", dut_snap(), model_snap());
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++;
    if (if_valid !== 1'b0 || imem_adr !== RESET_PC || fetch_count !== 32'd0 || misalign_err !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs got v=%b adr=%h cnt=%0d err=%b exp v=0 adr=%h cnt=0 err=0",
               if_valid, imem_adr, fetch_count, misalign_err, RESET_PC);
    end
  endtask

  task automatic test_boot_stream();
    step(1'b0, '0, 1'b1);
    n_checks++;
    if (if_valid !== 1'b0) begin
      n_fail++; $display("FAIL boot_cycle if_valid got=%b exp=0", if_valid);
    end
    step(1'b0, '0, 1'b1);
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h0 || if_inst !== 32'h1000_0000) begin
      n_fail++;
      $display("FAIL first_fetch got v=%b pc=%h inst=%h exp v=1 pc=0 inst=10000000", if_valid, if_pc, if_inst);
    end
    for (int i = 1; i <= 2; i++) begin
      step(1'b0, '0, 1'b1);
      n_checks++;
      if (if_pc !== 32'(4 * i) || if_valid !== 1'b1) begin
        n_fail++; $display("FAIL stream_pc got=%h exp=%h", if_pc, 32'(4 * i));
      end
    end
  endtask

  task automatic test_stall();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b0);
      n_checks++;
      if (if_pc !== 32'd8 || if_inst !== 32'h1000_0002 || if_pc_plus4 !== 32'd12 || imem_adr !== 32'd12) begin
        n_fail++;
        $display("FAIL stall_hold got pc=%h inst=%h p4=%h adr=%h exp 8/10000002/c/c",
                 if_pc, if_inst, if_pc_plus4, imem_adr);
      end
    end
    step(1'b0, '0, 1'b1);
    n_checks++;
    if (if_pc !== 32'd12 || if_inst !== 32'h1000_0003 || fetch_count !== 32'd3) begin
      n_fail++;
      $display("FAIL stall_release got pc=%h inst=%h cnt=%0d exp pc=c inst=10000003 cnt=3",
               if_pc, if_inst, fetch_count);
    end
  endtask

  task automatic test_redirect();
    logic [31:0] cnt_before;
    cnt_before = m_count;
    step(1'b1, 32'h40, 1'b1);
    n_checks++;
    if (if_valid !== 1'b0 || fetch_count !== cnt_before + 1 || imem_adr !== 32'h40) begin
      n_fail++;
      $display("FAIL redirect_flush got v=%b cnt=%0d adr=%h exp v=0 cnt=%0d adr=40",
               if_valid, fetch_count, imem_adr, cnt_before + 1);
    end
    step(1'b0, '0, 1'b1);
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h40 || if_inst !== 32'h1000_0010) begin
      n_fail++;
      $display("FAIL redirect_target got v=%b pc=%h inst=%h exp v=1 pc=40 inst=10000010",
               if_valid, if_pc, if_inst);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      logic        rv;
      logic [31:0] rpc;
      rv  = ($urandom_range(0, 7) == 0);
      rpc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_03FC);
      step(rv, rpc, 1'($urandom_range(0, 3) != 0));
      n_checks++;
      if (dut_snap() !== model_snap()) begin
        n_fail++;
        $display("FAIL random_step %0d got=%h exp=%h", i, dut_snap(), model_snap());
      end
    end
  endtask

  task automatic test_wrap();
    step(1'b1, 32'hFFFF_FFFC, 1'b1);
    step(1'b0, '0, 1'b1);
    n_checks++;
    if (if_pc !== 32'hFFFF_FFFC || if_pc_plus4 !== 32'h0 || if_inst !== 32'h4FFF_FFFF || imem_adr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_capture got pc=%h p4=%h inst=%h adr=%h exp fffffffc/0/4fffffff/0",
               if_pc, if_pc_plus4, if_inst, imem_adr);
    end
    step(1'b0, '0, 1'b1);
    n_checks++;
    if (if_pc !== 32'h0 || misalign_err !== 1'b0) begin
      n_fail++; $display("FAIL wrap_next got pc=%h err=%b exp pc=0 err=0", if_pc, misalign_err);
    end
  endtask

  task automatic test_boot_redirect();
    apply_reset();
    step(1'b1, 32'h80, 1'b1);
    n_checks++;
    if (if_valid !== 1'b0 || imem_adr !== 32'h80) begin
      n_fail++; $display("FAIL boot_redirect got v=%b adr=%h exp v=0 adr=80", if_valid, imem_adr);
    end
    step(1'b0, '0, 1'b1);
    n_checks++;
    if (if_valid !== 1'b1 || if_pc !== 32'h80 || if_inst !== 32'h1000_0020) begin
      n_fail++;
      $display("FAIL boot_redirect_target got v=%b pc=%h inst=%h exp v=1 pc=80 inst=10000020",
               if_valid, if_pc, if_inst);
    end
  endtask

  task automatic test_misalign();
    step(1'b0, '0, 1'b1);
    step(1'b1, 32'h42, 1'b1);
    n_checks++;
    if (misalign_err !== 1'b1 || if_valid !== 1'b0 || dut_snap() !== model_snap()) begin
      n_fail++;
      $display("FAIL misalign_trap got err=%b v=%b snap=%h exp err=1 v=0 snap=%h",
               misalign_err, if_valid, dut_snap(), model_snap());
    end
    for (int i = 0; i < 10; i++) begin
      step(1'($urandom_range(0, 1)), $urandom & 32'h0000_0FFC, 1'($urandom_range(0, 1)));
      n_checks++;
      if (misalign_err !== 1'b1 || if_valid !== 1'b0 || dut_snap() !== model_snap()) begin
        n_fail++;
        $display("FAIL halt_frozen %0d got=%h exp=%h", i, dut_snap(), model_snap());
      end
    end
    apply_reset();
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b1);
    n_checks++;
    if (misalign_err !== 1'b0 || if_valid !== 1'b1 || if_pc !== RESET_PC) begin
      n_fail++;
      $display("FAIL halt_reset_restart got err=%b v=%b pc=%h exp err=0 v=1 pc=%h",
               misalign_err, if_valid, if_pc, RESET_PC);
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);
    #1 rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (if_valid !== 1'b0 || imem_adr !== RESET_PC || fetch_count !== 32'd0 || dut_snap() !== model_snap()) begin
      n_fail++;
      $display("FAIL async_reset got=%h exp=%h", dut_snap(), model_snap());
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, 1'b1);
      n_checks++;
      if (dut_snap() !== model_snap()) begin
        n_fail++;
        $display("FAIL post_async_reset %0d got=%h exp=%h", i, dut_snap(), model_snap());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_boot_stream();
    test_stall();
    test_redirect();
    test_random();
    test_wrap();
    test_boot_redirect();
    test_random();
    test_misalign();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Fetch stage sitting directly upstream of the instruction ROM: owns the program counter and drives the ROM word address.
- Captures the ROM's combinational instruction into an IF/ID register and presents it to decode over a valid/ready handshake.
- Handles stalls from decode, PC redirects from execute (branch/jump), misaligned-redirect trapping, and a fetch counter.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset; must be word aligned.
- XLEN, 32, width of PC, instruction and counter.

Ports:
- clk, input, 1, single system clock; all state on rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- imem_adr, output, XLEN, byte address to the instruction ROM; equals the current PC register.
- imem_inst, input, XLEN, combinational instruction returned by the ROM for imem_adr, same cycle.
- redirect_valid, input, 1, execute requests a PC change this cycle.
- redirect_pc, input, XLEN, target byte address for the redirect.
- if_valid, output, 1, IF/ID register holds a valid instruction.
- if_ready, input, 1, decode accepts the IF/ID contents this cycle.
- if_pc, output, XLEN, PC of the held instruction.
- if_inst, output, XLEN, held instruction word.
- if_pc_plus4, output, XLEN, if_pc + 4, mod 2^XLEN.
- misalign_err, output, 1, sticky: a redirect target had bits [1:0] != 0.
- fetch_count, output, XLEN, number of completed handshakes (if_valid & if_ready) since reset.

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc = RESET_PC; state = BOOT.
  - if_valid = 0; if_pc = 0; if_inst = 0; if_pc_plus4 = 0.
  - misalign_err = 0; fetch_count = 0.
- imem_adr = pc at all times, combinationally. The ROM's word indexing is the ROM's concern; this block always issues full byte addresses.
- Define fire = if_valid & if_ready, and load_ok = !if_valid | if_ready.
- States:
  - BOOT: exactly one cycle after reset release. No capture; if_valid stays 0. Next state is RUN. A redirect seen in BOOT is handled exactly as in RUN, including the HALT path.
  - RUN, in priority order:
    - redirect_valid & redirect_pc[1:0] != 0: next state HALT; misalign_err <= 1; if_valid <= 0; pc unchanged.
    - redirect_valid, aligned: pc <= redirect_pc; if_valid <= 0 (flush). The instruction currently on imem_inst is discarded.
    - else if load_ok: if_pc <= pc; if_inst <= imem_inst; if_pc_plus4 <= pc + 4; if_valid <= 1; pc <= pc + 4.
    - else (stall): pc, IF/ID register and if_valid are held, so imem_adr and imem_inst stay stable.
  - HALT: if_valid = 0; pc and IF/ID register frozen; redirect_valid and if_ready ignored; misalign_err stays 1. Only rst_n exits HALT.
- fetch_count:
  - Increments by 1 in any cycle where fire is true, including a cycle where a redirect also flushes. The instruction accepted by decode in that cycle counts; the flush only empties the register for the following cycle.
  - Wraps mod 2^XLEN.
- Timing: throughput is 1 instruction/cycle with if_ready held high. The first if_valid rises 2 cycles after rst_n deasserts: one BOOT cycle, one capture cycle. After an aligned redirect, if_valid is low for exactly one cycle, then the target instruction appears.
- PC arithmetic: pc + 4 wraps mod 2^XLEN (32'hFFFF_FFFC -> 32'h0000_0000); no error is raised.
- While if_valid & !if_ready, the outputs if_pc, if_inst and if_pc_plus4 must not change.
- Reset asserted mid-stall or mid-redirect takes effect immediately: all outputs go to their reset values without waiting for clk.

Test Plan:
- Reset/boot, ROM word i = 32'h1000_0000+i, if_ready=1: if_valid rises the 2nd cycle after release with if_pc=0, if_inst=32'h1000_0000. Then if_pc=4, 8, 12 on consecutive cycles; fetch_count=3 after three accepts.
- Stall: hold if_ready=0 for 3 cycles while if_pc=8. if_pc/if_inst/if_pc_plus4 stay 8 / 32'h1000_0002 / 12 and imem_adr stays 12. On release, the next instruction is pc=12; no instruction is lost or duplicated.
- Aligned redirect to 32'h40 while if_valid=1 and if_ready=1: that cycle's handshake counts (fetch_count+1). Next cycle if_valid=0; following cycle if_pc=32'h40, if_inst=32'h1000_0010.
- Misaligned redirect to 32'h42: misalign_err=1 and if_valid=0 from the next cycle. 10 further cycles of redirects and if_ready toggling change nothing; rst_n pulse clears misalign_err and restarts at RESET_PC.
- Wrap-around: aligned redirect to 32'hFFFF_FFFC. Instruction captured with if_pc=32'hFFFF_FFFC and if_pc_plus4=0; next if_pc=0.
- Async reset: drop rst_n mid-cycle during a stall with if_valid=1. if_valid=0, imem_adr=RESET_PC and fetch_count=0 without waiting for a clk edge.
